// File: rtl/lcd_text_pkg.sv
`default_nettype none
// ============================================================
// Package : lcd_text_pkg
// Brief   : panel geometry, pixel/address types and cell-address helper
// Rev     : 1.0
// ============================================================
package lcd_text_pkg;

    localparam int H_ACTIVE = 480;
    localparam int V_ACTIVE = 272;
    localparam int COLS     = 60;
    localparam int ROWS     = 17;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int CELLS    = COLS * ROWS;

    typedef logic [15:0] rgb565_t;
    typedef logic [9:0]  vaddr_t;

    // Sideband that travels alongside the VRAM/font fetch.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       in_range;
        logic       cur_hit;
        logic [2:0] gx;
        logic [3:0] gy;
    } side_t;

    // row*60 + col without a multiplier.
    function automatic vaddr_t cell_addr(input logic [6:0] col, input logic [4:0] row);
        logic [11:0] w_sum;
        w_sum = {1'b0, row, 6'b0} - {5'b0, row, 2'b0} + {5'b0, col};
        return w_sum[9:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/font_rom.sv
`default_nettype none
// ============================================================
// Module : font_rom
// Brief  : 4096x8 glyph ROM ({code, row}), one-cycle registered read
// Rev    : 1.0
// ============================================================
module font_rom
    import lcd_text_pkg::*;
(
    input  logic        MEMORY_CLK,
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    localparam logic [7:0] c_glyph_a [GLYPH_H] = '{
        8'h18, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h7E, 8'h7E, 8'h66,
        8'h66, 8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Unlisted codes (including space) render as an empty cell.
    function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [3:0] gy);
        logic [7:0] w_row;
        w_row = 8'h00;
        case (code)
            8'h41:   w_row = c_glyph_a[gy];
            8'hDB:   w_row = 8'hFF;
            default: w_row = 8'h00;
        endcase
        return w_row;
    endfunction

    always_ff @(posedge MEMORY_CLK) begin
        data <= glyph_row(addr[11:4], addr[3:0]);
    end

endmodule
`default_nettype wire

// File: rtl/vram_text_renderer.sv
`default_nettype none
// ============================================================
// Module : vram_text_renderer
// Brief  : text VRAM + font ROM to RGB565 pixels, timing delayed to match
// Rev    : 1.0
// ============================================================
module vram_text_renderer
    import lcd_text_pkg::*;
#(
    parameter int VRAM_LAT  = 1,
    parameter int BLINK_BIT = 5
) (
    input  logic        MEMORY_CLK,
    input  logic        rst_n,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [9:0]  in_x,
    input  logic [8:0]  in_y,
    output logic [9:0]  v_adb,
    output logic        v_ceb,
    output logic        v_oce,
    output logic        v_resetb,
    input  logic [7:0]  v_dout,
    input  logic        cursor_en,
    input  logic [9:0]  cursor_addr,
    input  logic [15:0] fg_color,
    input  logic [15:0] bg_color,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [15:0] out_rgb
);

    logic [6:0]  w_col;
    logic [4:0]  w_row;
    vaddr_t      w_addr;
    side_t       w_s0;
    vaddr_t      r_v_adb;
    logic        r_v_ceb;
    side_t       r_pipe [0:VRAM_LAT];
    side_t       r_font;
    logic [11:0] w_font_addr;
    logic [7:0]  w_glyph;
    logic        w_pix;
    logic        r_vs_d;
    logic [7:0]  r_fcnt;

    assign w_col  = in_x[9:3];
    assign w_row  = in_y[8:4];
    assign w_addr = cell_addr(w_col, w_row);

    always_comb begin
        w_s0          = '0;
        w_s0.de       = in_de;
        w_s0.hs       = in_hs;
        w_s0.vs       = in_vs;
        w_s0.in_range = in_de & (w_col < 7'(COLS)) & (w_row < 5'(ROWS));
        w_s0.cur_hit  = cursor_en & (w_addr == cursor_addr) & (cursor_addr < 10'(CELLS));
        w_s0.gx       = in_x[2:0];
        w_s0.gy       = in_y[3:0];
    end

    assign v_adb    = r_v_adb;
    assign v_ceb    = r_v_ceb;
    assign v_oce    = 1'b1;
    assign v_resetb = 1'b0;

    // Address stage: hold the last address across blanking.
    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_v_adb   <= '0;
            r_v_ceb   <= 1'b0;
            r_pipe[0] <= '0;
        end else begin
            r_v_ceb   <= in_de;
            if (in_de) r_v_adb <= w_addr;
            r_pipe[0] <= w_s0;
        end
    end

    for (genvar k = 1; k <= VRAM_LAT; k++) begin : g_delay
        always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
            if (!rst_n) r_pipe[k] <= '0;
            else        r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign w_font_addr = {v_dout, r_pipe[VRAM_LAT].gy};

    font_rom u_font_rom (
        .MEMORY_CLK (MEMORY_CLK),
        .addr       (w_font_addr),
        .data       (w_glyph)
    );

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) r_font <= '0;
        else        r_font <= r_pipe[VRAM_LAT];
    end

    // Glyph bit 7 is the leftmost pixel; cursor inverts the whole cell.
    assign w_pix = w_glyph[3'(GLYPH_W - 1) - r_font.gx] ^ (r_font.cur_hit & r_fcnt[BLINK_BIT]);

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_de  <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_rgb <= '0;
        end else begin
            out_de  <= r_font.de;
            out_hs  <= r_font.hs;
            out_vs  <= r_font.vs;
            out_rgb <= (r_font.de && r_font.in_range) ? (w_pix ? fg_color : bg_color) : 16'h0000;
        end
    end

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_vs_d <= in_vs;
            if (in_vs && !r_vs_d) r_fcnt <= r_fcnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_text_renderer.sv
`default_nettype none
// ============================================================
// Module : tb_vram_text_renderer
// Brief  : directed vector bench for vram_text_renderer (VRAM_LAT 1 and 2)
// Rev    : 1.0
// ============================================================
module tb_vram_text_renderer;

    localparam logic [15:0] c_fg = 16'hF800;
    localparam logic [15:0] c_bg = 16'h001F;

    logic        MEMORY_CLK = 1'b0;
    logic        rst_n;
    logic        in_de, in_hs, in_vs;
    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic        cursor_en;
    logic [9:0]  cursor_addr;
    logic [15:0] fg_color, bg_color;

    logic [9:0]  v_adb, v_adb2;
    logic        v_ceb, v_ceb2, v_oce, v_oce2, v_resetb, v_resetb2;
    logic [7:0]  v_dout, v_dout2;
    logic        out_de, out_hs, out_vs, out2_de, out2_hs, out2_vs;
    logic [15:0] out_rgb, out2_rgb;

    int checks = 0;
    int errors = 0;

    always #5 MEMORY_CLK = ~MEMORY_CLK;

    vram_text_renderer #(.VRAM_LAT(1), .BLINK_BIT(5)) dut (
        .MEMORY_CLK (MEMORY_CLK), .rst_n (rst_n),
        .in_de (in_de), .in_hs (in_hs), .in_vs (in_vs), .in_x (in_x), .in_y (in_y),
        .v_adb (v_adb), .v_ceb (v_ceb), .v_oce (v_oce), .v_resetb (v_resetb), .v_dout (v_dout),
        .cursor_en (cursor_en), .cursor_addr (cursor_addr),
        .fg_color (fg_color), .bg_color (bg_color),
        .out_de (out_de), .out_hs (out_hs), .out_vs (out_vs), .out_rgb (out_rgb)
    );

    vram_text_renderer #(.VRAM_LAT(2), .BLINK_BIT(5)) dut2 (
        .MEMORY_CLK (MEMORY_CLK), .rst_n (rst_n),
        .in_de (in_de), .in_hs (in_hs), .in_vs (in_vs), .in_x (in_x), .in_y (in_y),
        .v_adb (v_adb2), .v_ceb (v_ceb2), .v_oce (v_oce2), .v_resetb (v_resetb2), .v_dout (v_dout2),
        .cursor_en (cursor_en), .cursor_addr (cursor_addr),
        .fg_color (fg_color), .bg_color (bg_color),
        .out_de (out2_de), .out_hs (out2_hs), .out_vs (out2_vs), .out_rgb (out2_rgb)
    );

    // VRAM models: one and two registered read stages.
    logic [7:0] vram [1024];
    logic [7:0] rd1, rd2_a, rd2_b;
    always @(posedge MEMORY_CLK) begin
        if (v_ceb)  rd1   <= vram[v_adb];
        if (v_ceb2) rd2_a <= vram[v_adb2];
        rd2_b <= rd2_a;
    end
    assign v_dout  = rd1;
    assign v_dout2 = rd2_b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MEMORY_CLK);
        #1;
    endtask

    // One pixel in, then idle; output must appear exactly four edges later.
    task automatic run_pix(input string nm, input logic [9:0] x, input logic [8:0] y,
                           input logic de, input logic [9:0] exp_adb, input logic [15:0] exp_rgb);
        in_x = x; in_y = y; in_de = de;
        tick();
        if (de) begin
            check({nm, " v_adb"}, 32'(v_adb), 32'(exp_adb));
            check({nm, " v_ceb"}, 32'(v_ceb), 32'd1);
        end
        in_de = 1'b0;
        tick();
        tick();
        check({nm, " early_de"}, 32'(out_de), 32'd0);
        tick();
        check({nm, " out_de"}, 32'(out_de), 32'(de));
        check({nm, " out_rgb"}, 32'(out_rgb), 32'(exp_rgb));
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            in_vs = 1'b1;
            tick();
            in_vs = 1'b0;
            tick();
        end
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        de;
        logic [9:0]  adb;
        logic [15:0] rgb;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sweep [8];
        sweep = '{c_bg, c_bg, c_bg, c_fg, c_fg, c_bg, c_bg, c_bg};

        for (int i = 0; i < 1024; i++) vram[i] = 8'h20;
        vram[0]    = 8'h41;
        vram[1019] = 8'hDB;

        vecs.push_back('{10'd0,   9'd0,   1'b1, 10'd0,    c_bg});
        vecs.push_back('{10'd479, 9'd271, 1'b1, 10'd1019, c_fg});
        vecs.push_back('{10'd8,   9'd16,  1'b1, 10'd61,   c_bg});
        vecs.push_back('{10'd500, 9'd0,   1'b1, 10'd62,   16'h0000});
        vecs.push_back('{10'd2,   9'd1,   1'b1, 10'd0,    c_fg});
        vecs.push_back('{10'd1,   9'd1,   1'b1, 10'd0,    c_bg});
        vecs.push_back('{10'd0,   9'd0,   1'b0, 10'd0,    16'h0000});
        for (int x = 0; x < 8; x++) vecs.push_back('{10'(x), 9'd0, 1'b1, 10'd0, sweep[x]});

        fg_color = c_fg; bg_color = c_bg;
        cursor_en = 1'b0; cursor_addr = 10'd0;
        in_hs = 1'b0; in_vs = 1'b0;
        in_x = 10'd0; in_y = 9'd0; in_de = 1'b1;
        rst_n = 1'b0;

        // Reset held with in_de active.
        repeat (3) tick();
        check("rst out_de",  32'(out_de),  32'd0);
        check("rst out_hs",  32'(out_hs),  32'd0);
        check("rst out_vs",  32'(out_vs),  32'd0);
        check("rst out_rgb", 32'(out_rgb), 32'd0);
        check("rst v_adb",   32'(v_adb),   32'd0);
        check("rst v_ceb",   32'(v_ceb),   32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("release early out_de", 32'(out_de), 32'd0);
        tick();
        check("release out_de",  32'(out_de),  32'd1);
        check("release out_rgb", 32'(out_rgb), 32'(c_bg));
        in_de = 1'b0;
        repeat (5) tick();

        foreach (vecs[i]) run_pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de,
                                  vecs[i].adb, vecs[i].rgb);

        // hs/vs latency through both pipe depths; frame counter becomes 1.
        in_de = 1'b0; in_hs = 1'b1; in_vs = 1'b1;
        tick();
        in_hs = 1'b0; in_vs = 1'b0;
        tick();
        tick();
        check("hs early", 32'(out_hs), 32'd0);
        tick();
        check("hs lat4",     32'(out_hs),  32'd1);
        check("vs lat4",     32'(out_vs),  32'd1);
        check("blank de",    32'(out_de),  32'd0);
        check("blank rgb",   32'(out_rgb), 32'd0);
        check("hs2 early",   32'(out2_hs), 32'd0);
        tick();
        check("hs width",    32'(out_hs),  32'd0);
        check("hs2 lat5",    32'(out2_hs), 32'd1);
        check("vs2 lat5",    32'(out2_vs), 32'd1);

        // Cursor: frame counter 32 -> blink phase on.
        vs_pulses(31);
        cursor_en = 1'b1; cursor_addr = 10'd0;
        run_pix("cur on x0",   10'd0, 9'd0, 1'b1, 10'd0, c_fg);
        run_pix("cur on x3",   10'd3, 9'd0, 1'b1, 10'd0, c_bg);
        cursor_addr = 10'd1;
        run_pix("cur blank",   10'd8, 9'd0, 1'b1, 10'd1, c_fg);
        run_pix("cur moved",   10'd0, 9'd0, 1'b1, 10'd0, c_bg);
        cursor_en = 1'b0;
        run_pix("cur disabled", 10'd8, 9'd0, 1'b1, 10'd1, c_bg);
        cursor_en = 1'b1; cursor_addr = 10'd0;
        vs_pulses(32);
        run_pix("cur off phase", 10'd0, 9'd0, 1'b1, 10'd0, c_bg);
        vs_pulses(32);
        run_pix("cur on again", 10'd0, 9'd0, 1'b1, 10'd0, c_fg);
        cursor_addr = 10'd1023;
        run_pix("cur 1023 x0",  10'd0,   9'd0,   1'b1, 10'd0,    c_bg);
        run_pix("cur 1023 end", 10'd479, 9'd271, 1'b1, 10'd1019, c_fg);
        cursor_addr = 10'd0;

        // Mid-frame reset while the pipe is full.
        in_y = 9'd0; in_de = 1'b1;
        for (int x = 190; x < 200; x++) begin
            in_x = 10'(x);
            tick();
        end
        in_x = 10'd200;
        check("midrst pre out_de", 32'(out_de), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst out_de",  32'(out_de),  32'd0);
        check("midrst out_rgb", 32'(out_rgb), 32'd0);
        tick();
        check("midrst next out_de",  32'(out_de),  32'd0);
        check("midrst next out_rgb", 32'(out_rgb), 32'd0);
        in_de = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        run_pix("fcnt cleared", 10'd0, 9'd0, 1'b1, 10'd0, c_bg);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
